// File: rtl/sdram_port_scheduler.sv
// SDRAM burst scheduler: arbitrates one write FIFO port, two read FIFO ports
// and refresh, offering one command at a time to the SDRAM command engine and
// keeping a wrapping start-address pointer per FIFO port.
module sdram_port_scheduler #(
    parameter int ADDR_W = 23,
    parameter int LEN_W  = 9,
    parameter int LVL_W  = 10
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iLOAD,
    input  logic [ADDR_W-1:0] iWR_BASE,
    input  logic [ADDR_W-1:0] iWR_MAX,
    input  logic [ADDR_W-1:0] iRD1_BASE,
    input  logic [ADDR_W-1:0] iRD1_MAX,
    input  logic [ADDR_W-1:0] iRD2_BASE,
    input  logic [ADDR_W-1:0] iRD2_MAX,
    input  logic [LEN_W-1:0]  iLEN,
    input  logic [LVL_W-1:0]  iWR_USED,
    input  logic [LVL_W-1:0]  iRD1_USED,
    input  logic [LVL_W-1:0]  iRD2_USED,
    input  logic              iREF_REQ,
    output logic              oCMD_VALID,
    output logic [1:0]        oCMD_PORT,
    output logic              oCMD_RD,
    output logic [ADDR_W-1:0] oCMD_ADDR,
    output logic [LEN_W-1:0]  oCMD_LEN,
    input  logic              iCMD_ACK,
    input  logic              iCMD_DONE
);

    // Fill levels and burst length are compared at a common width so neither is truncated.
    localparam int CMP_W = (LVL_W > LEN_W) ? LVL_W : LEN_W;
    // One extra bit so ptr+len can never overflow before the wrap comparison.
    localparam int SUM_W = ADDR_W + 1;

    localparam logic [1:0] PORT_WR  = 2'd0;
    localparam logic [1:0] PORT_RD1 = 2'd1;
    localparam logic [1:0] PORT_RD2 = 2'd2;
    localparam logic [1:0] PORT_REF = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lastGrant_q, lastGrant_d;
    logic [1:0]        cmdPort_q, cmdPort_d;
    logic              cmdRd_q, cmdRd_d;
    logic [ADDR_W-1:0] cmdAddr_q, cmdAddr_d;
    logic [LEN_W-1:0]  cmdLen_q, cmdLen_d;
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rd1Ptr_q, rd1Ptr_d;
    logic [ADDR_W-1:0] rd2Ptr_q, rd2Ptr_d;

    logic              lenNonZero;
    logic              reqWr, reqRd1, reqRd2;
    logic              pickValid;
    logic [1:0]        pickPort;
    logic [ADDR_W-1:0] pickAddr;

    // Next burst start: ptr+len, or back to base once that reaches the wrap limit.
    function automatic logic [ADDR_W-1:0] advancePtr(
        input logic [ADDR_W-1:0] ptr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] limit,
        input logic [LEN_W-1:0]  len
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, ptr} + SUM_W'(len);
        if (sum >= {1'b0, limit}) begin
            return base;
        end
        return sum[ADDR_W-1:0];
    endfunction

    // A zero burst length disables all FIFO ports; refresh is unaffected.
    assign lenNonZero = (iLEN != '0);
    assign reqWr      = lenNonZero && (CMP_W'(iWR_USED)  >= CMP_W'(iLEN));
    assign reqRd1     = lenNonZero && (CMP_W'(iRD1_USED) <  CMP_W'(iLEN));
    assign reqRd2     = lenNonZero && (CMP_W'(iRD2_USED) <  CMP_W'(iLEN));

    // Round-robin pick among the FIFO ports, searching from the port after the last grant.
    always_comb begin
        pickValid = reqWr | reqRd1 | reqRd2;
        pickPort  = PORT_WR;
        case (lastGrant_q)
            PORT_WR: begin
                if (reqRd1)      pickPort = PORT_RD1;
                else if (reqRd2) pickPort = PORT_RD2;
                else             pickPort = PORT_WR;
            end
            PORT_RD1: begin
                if (reqRd2)      pickPort = PORT_RD2;
                else if (reqWr)  pickPort = PORT_WR;
                else             pickPort = PORT_RD1;
            end
            default: begin
                if (reqWr)       pickPort = PORT_WR;
                else if (reqRd1) pickPort = PORT_RD1;
                else             pickPort = PORT_RD2;
            end
        endcase
    end

    // Start address of the picked port's next burst.
    always_comb begin
        case (pickPort)
            PORT_WR:  pickAddr = wrPtr_q;
            PORT_RD1: pickAddr = rd1Ptr_q;
            default:  pickAddr = rd2Ptr_q;
        endcase
    end

    // Command FSM: latch a grant in IDLE, hold it in OFFER until ACK, wait for DONE in BUSY.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        cmdPort_d   = cmdPort_q;
        cmdRd_d     = cmdRd_q;
        cmdAddr_d   = cmdAddr_q;
        cmdLen_d    = cmdLen_q;
        case (state_q)
            IDLE: begin
                if (iREF_REQ) begin
                    state_d   = OFFER;
                    cmdPort_d = PORT_REF;
                    cmdRd_d   = 1'b0;
                    cmdAddr_d = '0;
                    cmdLen_d  = '0;
                end else if (pickValid) begin
                    state_d     = OFFER;
                    cmdPort_d   = pickPort;
                    cmdRd_d     = (pickPort != PORT_WR);
                    cmdAddr_d   = pickAddr;
                    cmdLen_d    = iLEN;
                    lastGrant_d = pickPort;
                end
            end
            OFFER: begin
                if (iCMD_ACK) state_d = BUSY;
            end
            BUSY: begin
                if (iCMD_DONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer update: reload wins over the advance of a completing FIFO-port burst.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rd1Ptr_d = rd1Ptr_q;
        rd2Ptr_d = rd2Ptr_q;
        if (iLOAD) begin
            wrPtr_d  = iWR_BASE;
            rd1Ptr_d = iRD1_BASE;
            rd2Ptr_d = iRD2_BASE;
        end else if ((state_q == BUSY) && iCMD_DONE) begin
            case (cmdPort_q)
                PORT_WR:  wrPtr_d  = advancePtr(wrPtr_q,  iWR_BASE,  iWR_MAX,  iLEN);
                PORT_RD1: rd1Ptr_d = advancePtr(rd1Ptr_q, iRD1_BASE, iRD1_MAX, iLEN);
                PORT_RD2: rd2Ptr_d = advancePtr(rd2Ptr_q, iRD2_BASE, iRD2_MAX, iLEN);
                default:  wrPtr_d  = wrPtr_q;
            endcase
        end
    end

    // State registers; reset aborts any outstanding command and clears the pointers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            lastGrant_q <= PORT_RD2;
            cmdPort_q   <= PORT_WR;
            cmdRd_q     <= 1'b0;
            cmdAddr_q   <= '0;
            cmdLen_q    <= '0;
            wrPtr_q     <= '0;
            rd1Ptr_q    <= '0;
            rd2Ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            cmdPort_q   <= cmdPort_d;
            cmdRd_q     <= cmdRd_d;
            cmdAddr_q   <= cmdAddr_d;
            cmdLen_q    <= cmdLen_d;
            wrPtr_q     <= wrPtr_d;
            rd1Ptr_q    <= rd1Ptr_d;
            rd2Ptr_q    <= rd2Ptr_d;
        end
    end

    assign oCMD_VALID = (state_q == OFFER);
    assign oCMD_PORT  = cmdPort_q;
    assign oCMD_RD    = cmdRd_q;
    assign oCMD_ADDR  = cmdAddr_q;
    assign oCMD_LEN   = cmdLen_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Bench for sdram_port_scheduler: directed scenarios followed by randomized
// traffic, compared against a port/pointer reference model kept here.
module tb_sdram_port_scheduler;

    localparam int ADDR_W = 23;
    localparam int LEN_W  = 9;
    localparam int LVL_W  = 10;

    logic              iCLK;
    logic              iRST_N;
    logic              iLOAD;
    logic [ADDR_W-1:0] iWR_BASE, iWR_MAX;
    logic [ADDR_W-1:0] iRD1_BASE, iRD1_MAX;
    logic [ADDR_W-1:0] iRD2_BASE, iRD2_MAX;
    logic [LEN_W-1:0]  iLEN;
    logic [LVL_W-1:0]  iWR_USED, iRD1_USED, iRD2_USED;
    logic              iREF_REQ;
    logic              oCMD_VALID;
    logic [1:0]        oCMD_PORT;
    logic              oCMD_RD;
    logic [ADDR_W-1:0] oCMD_ADDR;
    logic [LEN_W-1:0]  oCMD_LEN;
    logic              iCMD_ACK;
    logic              iCMD_DONE;

    int errors = 0;
    int checks = 0;

    // Reference model: per-port pointer, base, limit and last granted FIFO port.
    int ptrM[3];
    int baseM[3];
    int maxM[3];
    int lastM;

    sdram_port_scheduler #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .LVL_W (LVL_W)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iLOAD     (iLOAD),
        .iWR_BASE  (iWR_BASE),
        .iWR_MAX   (iWR_MAX),
        .iRD1_BASE (iRD1_BASE),
        .iRD1_MAX  (iRD1_MAX),
        .iRD2_BASE (iRD2_BASE),
        .iRD2_MAX  (iRD2_MAX),
        .iLEN      (iLEN),
        .iWR_USED  (iWR_USED),
        .iRD1_USED (iRD1_USED),
        .iRD2_USED (iRD2_USED),
        .iREF_REQ  (iREF_REQ),
        .oCMD_VALID(oCMD_VALID),
        .oCMD_PORT (oCMD_PORT),
        .oCMD_RD   (oCMD_RD),
        .oCMD_ADDR (oCMD_ADDR),
        .oCMD_LEN  (oCMD_LEN),
        .iCMD_ACK  (iCMD_ACK),
        .iCMD_DONE (iCMD_DONE)
    );

    // 100 MHz free-running clock.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int wrU, input int rd1U, input int rd2U, input int len, input int refReq);
        iWR_USED  = LVL_W'(wrU);
        iRD1_USED = LVL_W'(rd1U);
        iRD2_USED = LVL_W'(rd2U);
        iLEN      = LEN_W'(len);
        iREF_REQ  = (refReq != 0);
    endtask

    task automatic setBases(input int wb, input int wm, input int r1b, input int r1m, input int r2b, input int r2m);
        iWR_BASE  = ADDR_W'(wb);  iWR_MAX  = ADDR_W'(wm);
        iRD1_BASE = ADDR_W'(r1b); iRD1_MAX = ADDR_W'(r1m);
        iRD2_BASE = ADDR_W'(r2b); iRD2_MAX = ADDR_W'(r2m);
        baseM[0] = wb;  maxM[0] = wm;
        baseM[1] = r1b; maxM[1] = r1m;
        baseM[2] = r2b; maxM[2] = r2m;
    endtask

    task automatic modelLoad();
        for (int i = 0; i < 3; i++) ptrM[i] = baseM[i];
    endtask

    // Reload pointers during a cycle in which nothing can request.
    task automatic pulseLoad();
        applyStimulus(0, 1000, 1000, 0, 0);
        iLOAD = 1'b1;
        step();
        iLOAD = 1'b0;
        modelLoad();
    endtask

    // Refresh first, then the first requesting FIFO port after the last one granted.
    function automatic int expectGrant(input int wrU, input int rd1U, input int rd2U,
                                       input int len, input int refReq, input int last);
        bit req[3];
        req[0] = (len != 0) && (wrU >= len);
        req[1] = (len != 0) && (rd1U < len);
        req[2] = (len != 0) && (rd2U < len);
        if (refReq != 0) return 3;
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    // One full transaction from the currently applied inputs: grant, hold, ACK, DONE.
    task automatic runCommand(input string tag, input int ackDelay, input int doneDelay,
                              input bit doneInOffer, input bit loadAtDone);
        int exp;
        int expAddr;
        int expLen;
        int len;
        len = int'(iLEN);
        exp = expectGrant(int'(iWR_USED), int'(iRD1_USED), int'(iRD2_USED), len, int'(iREF_REQ), lastM);
        step();
        iLOAD = 1'b0;
        if (exp < 0) begin
            checkOutput({tag, ".noReq"}, 32'(oCMD_VALID), 32'd0);
            return;
        end
        expAddr = (exp == 3) ? 0 : ptrM[exp];
        expLen  = (exp == 3) ? 0 : len;
        checkOutput({tag, ".valid"}, 32'(oCMD_VALID), 32'd1);
        checkOutput({tag, ".port"},  32'(oCMD_PORT),  exp);
        checkOutput({tag, ".rd"},    32'(oCMD_RD),    (exp == 1 || exp == 2) ? 32'd1 : 32'd0);
        checkOutput({tag, ".addr"},  32'(oCMD_ADDR),  expAddr);
        checkOutput({tag, ".len"},   32'(oCMD_LEN),   expLen);
        if (exp != 3) lastM = exp;
        for (int i = 0; i < ackDelay; i++) begin
            iWR_USED  = LVL_W'($urandom_range(0, 1023));
            iRD1_USED = LVL_W'($urandom_range(0, 1023));
            iRD2_USED = LVL_W'($urandom_range(0, 1023));
            iREF_REQ  = ($urandom_range(0, 1) == 1);
            iCMD_DONE = doneInOffer && (i == ackDelay / 2);
            step();
            iCMD_DONE = 1'b0;
            checkOutput({tag, ".holdValid"}, 32'(oCMD_VALID), 32'd1);
            checkOutput({tag, ".holdPort"},  32'(oCMD_PORT),  exp);
            checkOutput({tag, ".holdAddr"},  32'(oCMD_ADDR),  expAddr);
            checkOutput({tag, ".holdLen"},   32'(oCMD_LEN),   expLen);
        end
        iCMD_ACK = 1'b1;
        step();
        iCMD_ACK = 1'b0;
        checkOutput({tag, ".busyValid"}, 32'(oCMD_VALID), 32'd0);
        for (int i = 0; i < doneDelay; i++) step();
        iCMD_DONE = 1'b1;
        iLOAD     = loadAtDone;
        step();
        iCMD_DONE = 1'b0;
        iLOAD     = 1'b0;
        if (loadAtDone) begin
            modelLoad();
        end else if (exp != 3) begin
            ptrM[exp] = (ptrM[exp] + len >= maxM[exp]) ? baseM[exp] : ptrM[exp] + len;
        end
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        int len;
        int sel;
        iRST_N    = 1'b0;
        iLOAD     = 1'b0;
        iCMD_ACK  = 1'b0;
        iCMD_DONE = 1'b0;
        applyStimulus(0, 1000, 1000, 0, 0);
        setBases(0, 324480, 8320, 8832, 100000, 101000);
        for (int i = 0; i < 3; i++) ptrM[i] = 0;
        lastM = 2;

        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("reset.valid", 32'(oCMD_VALID), 32'd0);
        checkOutput("reset.port",  32'(oCMD_PORT),  32'd0);
        checkOutput("reset.rd",    32'(oCMD_RD),    32'd0);
        checkOutput("reset.addr",  32'(oCMD_ADDR),  32'd0);
        checkOutput("reset.len",   32'(oCMD_LEN),   32'd0);
        iRST_N = 1'b1;
        step();

        // Load together with the first write request, then a second write burst.
        applyStimulus(128, 1000, 1000, 128, 0);
        iLOAD = 1'b1;
        modelLoad();
        runCommand("wrFirst", 0, 0, 0, 0);
        applyStimulus(128, 1000, 1000, 128, 0);
        runCommand("wrSecond", 1, 1, 0, 0);

        // Write pointer placed one burst below its limit, then wraps to base 0.
        setBases(324352, 324480, 8320, 8832, 100000, 101000);
        pulseLoad();
        setBases(0, 324480, 8320, 8832, 100000, 101000);
        applyStimulus(128, 1000, 1000, 128, 0);
        runCommand("wrWrapA", 0, 2, 0, 0);
        applyStimulus(128, 1000, 1000, 128, 0);
        runCommand("wrWrapB", 0, 0, 0, 0);

        // Refresh beats all ports and leaves the round-robin position alone.
        applyStimulus(128, 0, 0, 128, 1);
        runCommand("refresh", 2, 1, 0, 0);
        applyStimulus(128, 0, 0, 128, 0);
        runCommand("afterRef", 0, 0, 0, 0);

        // All three ports requesting continuously.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(128, 0, 0, 128, 0);
            runCommand("roundRobin", 0, 1, 0, 0);
        end

        // ACK withheld 20 cycles with a stray DONE in the middle.
        applyStimulus(0, 1000, 0, 128, 0);
        runCommand("ackHold", 20, 0, 1, 0);

        // Load coinciding with completion of an RD1 burst at pointer 8448.
        pulseLoad();
        applyStimulus(0, 0, 1000, 128, 0);
        runCommand("rd1A", 0, 0, 0, 0);
        applyStimulus(0, 0, 1000, 128, 0);
        runCommand("rd1LoadAtDone", 1, 2, 0, 1);
        applyStimulus(0, 0, 1000, 128, 0);
        runCommand("rd1AfterLoad", 0, 0, 0, 0);

        // Reset asserted while a command is in BUSY.
        applyStimulus(128, 1000, 1000, 128, 0);
        step();
        checkOutput("rstBusy.offer", 32'(oCMD_VALID), 32'd1);
        iCMD_ACK = 1'b1;
        step();
        iCMD_ACK = 1'b0;
        iRST_N = 1'b0;
        #1;
        checkOutput("rstBusy.valid", 32'(oCMD_VALID), 32'd0);
        checkOutput("rstBusy.port",  32'(oCMD_PORT),  32'd0);
        checkOutput("rstBusy.rd",    32'(oCMD_RD),    32'd0);
        checkOutput("rstBusy.addr",  32'(oCMD_ADDR),  32'd0);
        checkOutput("rstBusy.len",   32'(oCMD_LEN),   32'd0);
        for (int i = 0; i < 3; i++) ptrM[i] = 0;
        lastM = 2;
        applyStimulus(0, 1000, 1000, 0, 0);
        step();
        iRST_N = 1'b1;
        iCMD_DONE = 1'b1;
        step();
        iCMD_DONE = 1'b0;
        checkOutput("rstBusy.idleDone", 32'(oCMD_VALID), 32'd0);

        // After reset the round robin starts again at WR.
        applyStimulus(128, 0, 0, 128, 0);
        iLOAD = 1'b1;
        modelLoad();
        runCommand("postRst", 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(128, 0, 0, 128, 0);
            runCommand("postRst", 0, 0, 0, 0);
        end

        // Randomized traffic with small wrap windows and occasional reloads.
        setBases(1000, 1600, 8320, 8832, 50000, 50300);
        pulseLoad();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) pulseLoad();
            sel = int'($urandom_range(0, 7));
            len = (sel == 0) ? 0 : (sel < 4) ? 64 : (sel < 6) ? 128 : 200;
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), len, ($urandom_range(0, 7) == 0) ? 1 : 0);
            runCommand("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
